// File: rtl/cpc_ram_bank_ctrl.sv
// CPC expansion RAM banking core: captures &7Fxx RAM-config writes and maps Z80 16K pages
// onto 512K SRAM blocks. Optional config readback on &7Fxx IO reads when CFG_READBACK_EN is defined.
module cpc_ram_bank_ctrl #(
    parameter int unsigned NBANK_BITS = 3,
    parameter logic [7:0]  CFG_RESET  = 8'h00
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_mreq_b,
    input  logic                  i_ioreq_b,
    input  logic                  i_rfsh_b,
    input  logic                  i_rd_b,
    input  logic                  i_wr_b,
    input  logic                  i_a15,
    input  logic                  i_a14,
    input  logic [7:0]            i_d,
    output logic [NBANK_BITS+1:0] o_hiadr,
    output logic                  o_ramcs_b,
    output logic                  o_ramoe_b,
    output logic                  o_ramwe_b,
    output logic                  o_ramdis
`ifdef CFG_READBACK_EN
    ,
    output logic [7:0]            o_dout,
    output logic                  o_doe
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StRd,
        StWr
    } state_t;

    state_t                  r_state;
    logic [5:0]              r_cfg;
    logic                    r_iowr;
    logic [NBANK_BITS+1:0]   r_hiadr;
    logic                    r_ramcs_b;

    logic [1:0]              w_page;
    logic [2:0]              w_mode;
    logic [NBANK_BITS-1:0]   w_bank;
    logic                    w_hit;
    logic [1:0]              w_blk;
    logic                    w_mem_hit;
    logic                    w_iowr;
    logic                    w_cfg_cap;

    // Bank field is zero-extended or truncated to NBANK_BITS; extra data bits never wrap in.
    function automatic logic [NBANK_BITS-1:0] f_bank(input logic [2:0] b);
        logic [2:0] t;
        t      = b;
        f_bank = '0;
        for (int i = 0; i < int'(NBANK_BITS); i++) begin
            f_bank[i] = t[0];
            t         = t >> 1;
        end
    endfunction

    assign w_page = {i_a15, i_a14};
    assign w_mode = r_cfg[2:0];
    assign w_bank = f_bank(r_cfg[5:3]);

    always_comb begin
        w_hit = 1'b0;
        w_blk = w_page;
        case (w_mode)
            3'd0: begin
                w_hit = 1'b0;
            end
            3'd1, 3'd3: begin
                w_hit = (w_page == 2'd3);
                w_blk = 2'd3;
            end
            3'd2: begin
                w_hit = 1'b1;
                w_blk = w_page;
            end
            default: begin
                w_hit = (w_page == 2'd1);
                w_blk = w_mode[1:0];
            end
        endcase
    end

    assign w_mem_hit = !i_mreq_b && i_rfsh_b && w_hit;
    assign o_ramdis  = w_mem_hit;

    assign w_iowr = !i_ioreq_b && !i_wr_b && !i_a15 && i_a14;

    // Rising edge of the IO-write qualifier only, so a long IOREQ gives a single capture.
    // A concurrent memory request wins and the IO write is dropped.
    assign w_cfg_cap = w_iowr && !r_iowr && (i_d[7:6] == 2'b11) && i_mreq_b &&
                       (r_state == StIdle);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_iowr <= 1'b0;
            r_cfg  <= CFG_RESET[5:0];
        end else begin
            r_iowr <= w_iowr;
            if (w_cfg_cap) begin
                r_cfg <= i_d[5:0];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_hiadr   <= '0;
            r_ramcs_b <= 1'b1;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_mem_hit) begin
                        r_hiadr   <= {w_bank, w_blk};
                        r_ramcs_b <= 1'b0;
                        if (!i_rd_b) begin
                            r_state <= StRd;
                        end else if (!i_wr_b) begin
                            r_state <= StWr;
                        end else begin
                            r_state <= StArm;
                        end
                    end
                end
                StArm: begin
                    if (!i_rd_b) begin
                        r_state <= StRd;
                    end else if (!i_wr_b) begin
                        r_state <= StWr;
                    end else if (i_mreq_b) begin
                        r_state   <= StIdle;
                        r_ramcs_b <= 1'b1;
                    end
                end
                StRd, StWr: begin
                    if (i_mreq_b) begin
                        r_state   <= StIdle;
                        r_ramcs_b <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= StIdle;
                    r_ramcs_b <= 1'b1;
                end
            endcase
        end
    end

    assign o_hiadr   = r_hiadr;
    assign o_ramcs_b = r_ramcs_b;
    // Strobes follow the Z80 strobes directly so they end without waiting for a clock.
    assign o_ramoe_b = (r_state != StRd) || i_rd_b;
    assign o_ramwe_b = (r_state != StWr) || i_wr_b;

`ifdef CFG_READBACK_EN
    logic w_iord;

    assign w_iord = !i_ioreq_b && !i_rd_b && !i_a15 && i_a14;
    assign o_doe  = w_iord && !i_reset;
    assign o_dout = {2'b11, r_cfg};
`endif

endmodule

// File: tb/tb_cpc_ram_bank_ctrl.sv
// Self-checking bench for cpc_ram_bank_ctrl: table of bus cycles plus hand-written corner sequences.
// Readback checks are compiled only when CFG_READBACK_EN is defined.
module tb_cpc_ram_bank_ctrl;

    logic       clk;
    logic       reset;
    logic       mreq_b, ioreq_b, rfsh_b, rd_b, wr_b, a15, a14;
    logic [7:0] d;
    logic [4:0] hiadr;
    logic       ramcs_b, ramoe_b, ramwe_b, ramdis;
`ifdef CFG_READBACK_EN
    logic [7:0] dout;
    logic       doe;
`endif

    int n_cmp;
    int n_bad;

    cpc_ram_bank_ctrl #(
        .NBANK_BITS(3),
        .CFG_RESET (8'h00)
    ) u_dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_mreq_b (mreq_b),
        .i_ioreq_b(ioreq_b),
        .i_rfsh_b (rfsh_b),
        .i_rd_b   (rd_b),
        .i_wr_b   (wr_b),
        .i_a15    (a15),
        .i_a14    (a14),
        .i_d      (d),
        .o_hiadr  (hiadr),
        .o_ramcs_b(ramcs_b),
        .o_ramoe_b(ramoe_b),
        .o_ramwe_b(ramwe_b),
        .o_ramdis (ramdis)
`ifdef CFG_READBACK_EN
        ,
        .o_dout   (dout),
        .o_doe    (doe)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       io, mreq, rfsh, rd, wr, a15, a14;
        logic [7:0] d;
        logic [4:0] hiadr;
        logic       cs, oe, we, dis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic io, input logic mreq, input logic rfsh,
                                input logic rd, input logic wr, input logic a15, input logic a14,
                                input logic [7:0] dd, input logic [4:0] ha, input logic cs,
                                input logic oe, input logic we, input logic dis);
        vec_t v;
        v.io = io; v.mreq = mreq; v.rfsh = rfsh; v.rd = rd; v.wr = wr;
        v.a15 = a15; v.a14 = a14; v.d = dd;
        v.hiadr = ha; v.cs = cs; v.oe = oe; v.we = we; v.dis = dis;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] got,
                       input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic chk_outs(input int idx, input logic [4:0] ha, input logic cs,
                            input logic oe, input logic we, input logic dis);
        chk("hiadr", idx, {3'b0, hiadr}, {3'b0, ha});
        chk("ramcs_b", idx, {7'b0, ramcs_b}, {7'b0, cs});
        chk("ramoe_b", idx, {7'b0, ramoe_b}, {7'b0, oe});
        chk("ramwe_b", idx, {7'b0, ramwe_b}, {7'b0, we});
        chk("ramdis", idx, {7'b0, ramdis}, {7'b0, dis});
    endtask

    task automatic drive(input vec_t v);
        ioreq_b = v.io; mreq_b = v.mreq; rfsh_b = v.rfsh; rd_b = v.rd; wr_b = v.wr;
        a15 = v.a15; a14 = v.a14; d = v.d;
    endtask

    task automatic bus_idle();
        ioreq_b = 1'b1; mreq_b = 1'b1; rfsh_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1;
        a15 = 1'b0; a14 = 1'b0; d = 8'h00;
    endtask

    task automatic io_write(input logic [7:0] dd);
        ioreq_b = 1'b0; wr_b = 1'b0; a15 = 1'b0; a14 = 1'b1; d = dd;
        repeat (2) @(posedge clk);
        #1;
        bus_idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        bus_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_outs(1000, 5'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Mode 0 after reset: nothing maps.
        mreq_b = 1'b0; rd_b = 1'b0; a15 = 1'b1; a14 = 1'b1;
        @(posedge clk);
        #1;
        chk_outs(1001, 5'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        bus_idle();
        @(posedge clk);
        #1;

        //                io mrq rfs rd wr a15 a14 d      hiadr  cs oe we dis
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 8'hC2, 5'h00, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 8'hC2, 5'h00, 1, 1, 1, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 8'h00, 5'h00, 1, 1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 0, 8'h00, 5'h00, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 1, 1, 1, 0, 0, 8'h00, 5'h00, 0, 1, 1, 1));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 8'h00, 5'h00, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 8'hD1, 5'h00, 1, 1, 1, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 8'h00, 5'h00, 1, 1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 1, 1, 8'h00, 5'h0B, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 1, 1, 1, 1, 1, 8'h00, 5'h0B, 0, 1, 1, 1));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 8'h00, 5'h0B, 1, 1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 1, 8'h00, 5'h0B, 1, 1, 1, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 8'h00, 5'h0B, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 8'hC7, 5'h0B, 1, 1, 1, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 8'h00, 5'h0B, 1, 1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 1, 8'h00, 5'h03, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 8'h00, 5'h03, 1, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 1, 8'h00, 5'h03, 1, 1, 1, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 8'h00, 5'h03, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 8'h42, 5'h03, 1, 1, 1, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 8'h00, 5'h03, 1, 1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 1, 8'h00, 5'h03, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 8'h00, 5'h03, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 8'hD1, 5'h03, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 8'hC2, 5'h03, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 8'hC2, 5'h03, 1, 1, 1, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 8'h00, 5'h03, 1, 1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 1, 1, 1, 8'h00, 5'h0B, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 8'h00, 5'h0B, 1, 1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 1, 1, 1, 1, 8'h00, 5'h0B, 0, 1, 1, 1));
        vecs.push_back(mk(1, 0, 1, 1, 0, 1, 1, 8'h00, 5'h0B, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 8'h00, 5'h0B, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 8'hC2, 5'h0B, 1, 1, 1, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 8'h00, 5'h0B, 1, 1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 1, 1, 1, 8'h00, 5'h0B, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 8'h00, 5'h0B, 1, 1, 1, 0));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            chk_outs(i, vecs[i].hiadr, vecs[i].cs, vecs[i].oe, vecs[i].we, vecs[i].dis);
        end

        // Reset asserted mid-write (cfg is D1: bank2 mode1).
        mreq_b = 1'b0; wr_b = 1'b0; a15 = 1'b1; a14 = 1'b1;
        @(posedge clk);
        #1;
        chk("ramwe_b pre-reset", 2000, {7'b0, ramwe_b}, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        chk_outs(2001, 5'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        bus_idle();
        @(posedge clk);
        #1;
        mreq_b = 1'b0; rd_b = 1'b0; a15 = 1'b1; a14 = 1'b1;
        @(posedge clk);
        #1;
        chk_outs(2002, 5'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        bus_idle();
        @(posedge clk);
        #1;

        // Combinational RAMDIS before the edge, and OE ending with RD_B.
        io_write(8'hC2);
        mreq_b = 1'b0; rd_b = 1'b0; a15 = 1'b1; a14 = 1'b0;
        #1;
        chk("ramdis comb", 3000, {7'b0, ramdis}, 8'h01);
        @(posedge clk);
        #1;
        chk_outs(3001, 5'h02, 1'b0, 1'b0, 1'b1, 1'b1);
        rd_b = 1'b1;
        #1;
        chk("ramoe_b release", 3002, {7'b0, ramoe_b}, 8'h01);
        bus_idle();
        @(posedge clk);
        #1;

`ifdef CFG_READBACK_EN
        io_write(8'hE5);
        ioreq_b = 1'b0; rd_b = 1'b0; a15 = 1'b0; a14 = 1'b1;
        #1;
        chk("doe 7f", 4000, {7'b0, doe}, 8'h01);
        chk("dout 7f", 4001, dout, 8'hE5);
        a15 = 1'b1; a14 = 1'b0;
        #1;
        chk("doe bc", 4002, {7'b0, doe}, 8'h00);
        bus_idle();
        #1;
        chk("doe idle", 4003, {7'b0, doe}, 8'h00);
        @(posedge clk);
        #1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
